// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, sequencer states and op classification
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRA  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response handshake bundle of the sequential ALU
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_control, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - shifter: one bit per cycle by default, barrel shifter
// under ALU_SEQ_FAST_SHIFT_EN (o_result is then the full shift of i_a).
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
`ifndef ALU_SEQ_FAST_SHIFT_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
`endif
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_result,
  output logic             o_last
);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  always_comb begin
    o_result = i_a;
    case (i_op)
      ALU_SLL: o_result = i_a << i_shamt;
      ALU_SRL: o_result = i_a >> i_shamt;
      ALU_SRA: o_result = WIDTH'($signed(i_a) >>> i_shamt);
      default: o_result = i_a;
    endcase
  end
  assign o_last = 1'b1;
`else
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  alu_op_t          r_op;
  logic [WIDTH-1:0] w_step;

  // o_result is the value r_work takes on the next edge, so the top can
  // register the final result on the same edge as the last shift.
  always_comb begin
    w_step = r_work;
    case (r_op)
      ALU_SLL: w_step = {r_work[WIDTH-2:0], 1'b0};
      ALU_SRL: w_step = {1'b0, r_work[WIDTH-1:1]};
      ALU_SRA: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_step = r_work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_op   <= ALU_ADD;
    end else if (i_load) begin
      r_work <= i_a;
      r_cnt  <= i_shamt;
      r_op   <= i_op;
    end else if (r_cnt != '0) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_result = w_step;
  assign o_last   = (r_cnt == SHW'(1));
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU behind valid/ready; ALU_SEQ_FAST_SHIFT_EN
// selects single-cycle shifts instead of one bit per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam logic FAST_SHIFT = 1'b1;
`else
  localparam logic FAST_SHIFT = 1'b0;
`endif

  alu_state_t       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  alu_op_t          w_op;
  logic             w_legal;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept;
  logic             w_iterate;
  logic             w_last;
  logic [WIDTH-1:0] w_shift_result;
  logic [WIDTH-1:0] w_alu_result;

  assign w_op      = alu_op_t'(bus.alu_control);
  assign w_legal   = bus.alu_control < 4'd10;
  assign w_shamt   = bus.b[SHW-1:0];
  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_iterate = !FAST_SHIFT && is_shift(w_op) && (w_shamt != '0);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .i_op     (w_op),
    .i_a      (bus.a),
    .i_shamt  (w_shamt),
    .o_result (w_shift_result),
    .o_last   (w_last)
  );
`else
  logic w_load;
  assign w_load = w_accept && w_iterate;

  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_op     (w_op),
    .i_a      (bus.a),
    .i_shamt  (w_shamt),
    .o_result (w_shift_result),
    .o_last   (w_last)
  );
`endif

  // Iterative shifts with k==0 leave a unchanged, so a is the result here.
  always_comb begin
    w_alu_result = '0;
    case (w_op)
      ALU_ADD:  w_alu_result = bus.a + bus.b;
      ALU_SUB:  w_alu_result = bus.a - bus.b;
      ALU_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      ALU_XOR:  w_alu_result = bus.a ^ bus.b;
      ALU_OR:   w_alu_result = bus.a | bus.b;
      ALU_AND:  w_alu_result = bus.a & bus.b;
      ALU_SLL, ALU_SRL, ALU_SRA:
                w_alu_result = FAST_SHIFT ? w_shift_result : bus.a;
      default:  w_alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (w_iterate) begin
              r_state <= SHIFT;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_alu_result;
              r_zero      <= (w_alu_result == '0);
              r_illegal   <= !w_legal;
            end
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_shift_result;
            r_zero      <= (w_shift_result == '0);
            r_illegal   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle integer ALU that consumes the 4-bit ALU control code produced by the ALU decoder and executes it on two operands behind a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. Shifts iterate one bit position per cycle, trading latency for area. It sits in the execute stage of the multi-cycle core variant, between operand select and writeback.

## Interface
- WIDTH, 32: operand and result width. Must be a power of two, at least 8.
- clk  input  1: clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high reset.
- in_valid  input  1: op, a and b are valid.
- in_ready  output  1: the block can accept an operation.
- alu_control  input  4: operation code (see Operation).
- a  input  WIDTH: operand A.
- b  input  WIDTH: operand B; for shifts, b[$clog2(WIDTH)-1:0] is the shift amount.
- out_valid  output  1: result is valid.
- out_ready  input  1: the consumer accepts the result.
- result  output  WIDTH: operation result.
- zero  output  1: result == 0.
- illegal  output  1: the accepted code was undefined (10–15).

## Operation
- Codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU.
  - 5 XOR, 6 SRA, 7 SRL, 8 OR, 9 AND.
  - 10–15 illegal.
- All arithmetic is modulo 2^WIDTH; overflow is ignored.
- SLT/SLTU produce 1 or 0, zero-extended to WIDTH.
- Shift amount: upper bits of b are ignored.
- Illegal codes produce result 0, illegal=1, latency 1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid, latch op, a and shift amount k.
    - Non-shift op, or shift with k==0: compute the result and go to DONE.
    - Shift with k>0: go to SHIFT.
  - SHIFT: each cycle, shift the working register by one bit and decrement k.
    - SRA shifts in the sign bit; SLL and SRL shift in 0.
    - Go to DONE when k reaches 0.
  - DONE: out_valid=1; result, zero and illegal are held stable.
    - On out_ready, return to IDLE.
- in_ready is 0 in SHIFT and DONE; operations never overlap.
- Inputs are ignored unless in_valid and in_ready are both 1.

## Timing
- Reset values: in_ready=1 (once reset is released), out_valid=0, result=0, zero=0, illegal=0; state=IDLE.
- Latency is counted from the accept edge to the first cycle out_valid=1:
  - 1 cycle for non-shift ops and for shifts with k==0.
  - 1+k cycles for shifts with k>0; maximum 1+(WIDTH-1).
- Throughput with out_ready held at 1: one op every latency+1 cycles (one cycle in IDLE plus the latency).
- out_valid with out_ready low: result holds indefinitely; no data loss.
- Simultaneous out_ready and in_valid in DONE: the new op is not accepted that cycle; it is accepted in the following IDLE cycle.
- Reset mid-operation (SHIFT or DONE): next cycle state=IDLE, out_valid=0, the result is discarded, and outputs return to reset values.
- All outputs are registered; there is no combinational path from inputs to outputs except in_ready, which depends only on state.

## Configuration
- ALU_SEQ_FAST_SHIFT_EN
  - Defined: shifts use a single-cycle barrel shifter. Every op has latency 1 and the SHIFT state is never entered.
  - Undefined: iterative shifting as described in Operation.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package alu_pkg holds:
  - alu_op_t enum: ALU_ADD=4'h0 … ALU_AND=4'h9.
  - The state enum {IDLE, SHIFT, DONE}.
  - A helper function is_shift(alu_op_t).
- The ALU decoder is updated to emit alu_op_t.
- One sub-module: alu_shift_unit, holding the working register and counter.
  - Iterative in the default build; barrel shifter under ALU_SEQ_FAST_SHIFT_EN.

## Test plan
- Reset, then ADD a=0x0000_0005, b=0x0000_0003 → result=0x8 one cycle after accept; zero=0; illegal=0.
- SUB a=7, b=7 → result=0, zero=1; SLT a=0xFFFF_FFFF, b=1 → 1; SLTU with the same operands → 0.
- SRA a=0x8000_0000, b=4 → result=0xF800_0000 with out_valid 5 cycles after accept (1 cycle under the macro); SLL a=1, b=0x25 → 0x20 (k=5).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable and in_ready=0 throughout; single-cycle out_ready → IDLE next cycle.
- alu_control=4'hC → result=0, illegal=1, latency 1; the next legal op clears illegal.
- Assert reset during the 3rd SHIFT cycle of SRL k=20 → next cycle out_valid=0, in_ready=1, result=0; a following ADD completes normally.
